// File: rtl/sat_timer_bank.sv
// Bank of independent saturating timers sharing one tick and one config bus.
// Each channel counts down to its floor (one-shot or auto-reload) or up to its reload.
module sat_timer_bank #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [CH_BITS-1:0]        cfg_ch,
  input  logic [WIDTH-1:0]          cfg_reload,
  input  logic [WIDTH-1:0]          cfg_floor,
  input  logic [1:0]                cfg_mode,
  input  logic [CHANNELS-1:0]       start,
  input  logic                      tick,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       at_limit,
  output logic [CHANNELS-1:0]       expire,
  output logic [CHANNELS-1:0]       busy
);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  localparam logic [1:0] MODE_AUTO = 2'b10;
  localparam logic [1:0] MODE_UP   = 2'b11;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] lo);
    return (v > lo) ? (v - ONE) : lo;
  endfunction

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] hi);
    return (v < hi) ? (v + ONE) : hi;
  endfunction

  function automatic logic [WIDTH-1:0] max_w(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] min_w(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_p1;
    logic [WIDTH-1:0] reload_p1;
    logic [WIDTH-1:0] floor_p1;
    logic [1:0]       mode_p1;
    logic             busy_p1;
    logic             expire_p1;
    logic             sel;
    logic [WIDTH-1:0] dec_nxt;
    logic [WIDTH-1:0] inc_nxt;

    assign sel     = cfg_we && (cfg_ch == CH_BITS'(i));
    assign dec_nxt = sat_dec(cnt_p1, floor_p1);
    assign inc_nxt = sat_inc(cnt_p1, reload_p1);

    // stage p1: start/tick act on the config held before this edge
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_p1    <= '0;
        reload_p1 <= '0;
        floor_p1  <= '0;
        mode_p1   <= MODE_OFF;
        busy_p1   <= 1'b0;
        expire_p1 <= 1'b0;
      end else begin
        expire_p1 <= 1'b0;
        if (start[i] && (mode_p1 != MODE_OFF)) begin
          if (mode_p1 == MODE_UP) begin
            cnt_p1 <= min_w(floor_p1, reload_p1);
            if (floor_p1 >= reload_p1) begin
              expire_p1 <= 1'b1;
              busy_p1   <= 1'b0;
            end else begin
              busy_p1   <= 1'b1;
            end
          end else begin
            cnt_p1 <= max_w(reload_p1, floor_p1);
            if (reload_p1 <= floor_p1) begin
              expire_p1 <= 1'b1;
              busy_p1   <= (mode_p1 == MODE_AUTO);
            end else begin
              busy_p1   <= 1'b1;
            end
          end
        end else if (tick && busy_p1) begin
          case (mode_p1)
            MODE_ONE: begin
              cnt_p1 <= dec_nxt;
              if (dec_nxt == floor_p1) begin
                busy_p1   <= 1'b0;
                expire_p1 <= (cnt_p1 != floor_p1);
              end
            end
            MODE_AUTO: begin
              // at floor: reload, or sit at floor if the period degenerates to 1
              if (cnt_p1 > floor_p1) begin
                cnt_p1    <= dec_nxt;
                expire_p1 <= (dec_nxt == floor_p1);
              end else if (reload_p1 <= floor_p1) begin
                cnt_p1    <= floor_p1;
                expire_p1 <= 1'b1;
              end else begin
                cnt_p1    <= reload_p1;
              end
            end
            MODE_UP: begin
              cnt_p1 <= inc_nxt;
              if (inc_nxt == reload_p1) begin
                busy_p1   <= 1'b0;
                expire_p1 <= (cnt_p1 != reload_p1);
              end
            end
            default: busy_p1 <= 1'b0;
          endcase
        end
        // a config write lands last so that selecting mode 00 always drops busy
        if (sel) begin
          reload_p1 <= cfg_reload;
          floor_p1  <= cfg_floor;
          mode_p1   <= cfg_mode;
          if (cfg_mode == MODE_OFF) busy_p1 <= 1'b0;
        end
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_p1;
    assign busy[i]                 = busy_p1;
    assign expire[i]               = expire_p1;
    assign at_limit[i]             = (mode_p1 != MODE_OFF) &&
                                     (cnt_p1 == ((mode_p1 == MODE_UP) ? reload_p1 : floor_p1));
  end

endmodule

// File: tb/tb_sat_timer_bank.sv
// Directed bench for sat_timer_bank: the driver queues expected channel state per edge,
// a monitor pops and compares one entry after each rising edge.
module tb_sat_timer_bank;

  localparam int WIDTH    = 5;
  localparam int CHANNELS = 4;
  localparam int CH_BITS  = 2;
  localparam int ALL      = 99;

  logic                      clk;
  logic                      reset;
  logic                      cfg_we;
  logic [CH_BITS-1:0]        cfg_ch;
  logic [WIDTH-1:0]          cfg_reload;
  logic [WIDTH-1:0]          cfg_floor;
  logic [1:0]                cfg_mode;
  logic [CHANNELS-1:0]       start;
  logic                      tick;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       at_limit;
  logic [CHANNELS-1:0]       expire;
  logic [CHANNELS-1:0]       busy;

  sat_timer_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_BITS(CH_BITS)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_reload(cfg_reload), .cfg_floor(cfg_floor), .cfg_mode(cfg_mode),
    .start(start), .tick(tick), .count(count), .at_limit(at_limit),
    .expire(expire), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    int             ch;
    logic [WIDTH-1:0] cnt;
    logic           ex;
    logic           bz;
    logic           al;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic drive(input logic rst_i, input logic tick_i, input logic [CHANNELS-1:0] start_i,
                       input logic we_i, input logic [CH_BITS-1:0] ch_i,
                       input logic [WIDTH-1:0] rl_i, input logic [WIDTH-1:0] fl_i,
                       input logic [1:0] md_i);
    @(negedge clk);
    reset      = rst_i;
    tick       = tick_i;
    start      = start_i;
    cfg_we     = we_i;
    cfg_ch     = ch_i;
    cfg_reload = rl_i;
    cfg_floor  = fl_i;
    cfg_mode   = md_i;
  endtask

  task automatic expect_ch(input string tag, input int ch, input int cnt,
                           input logic ex, input logic bz, input logic al);
    exp_t e;
    e.tag = tag;
    e.ch  = ch;
    e.cnt = WIDTH'(cnt);
    e.ex  = ex;
    e.bz  = bz;
    e.al  = al;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [WIDTH-1:0] c;
    bit bad;
    bad = 0;
    tests++;
    if (e.ch == ALL) begin
      if (count !== '0 || busy !== '0 || expire !== '0 || at_limit !== '0) begin
        $display("FAIL %s all-zero: count=%h busy=%b expire=%b at_limit=%b, want all 0",
                 e.tag, count, busy, expire, at_limit);
        bad = 1;
      end
    end else begin
      c = count[e.ch*WIDTH +: WIDTH];
      if (c !== e.cnt) begin
        $display("FAIL %s ch%0d count got %0d want %0d", e.tag, e.ch, c, e.cnt);
        bad = 1;
      end
      if (expire[e.ch] !== e.ex) begin
        $display("FAIL %s ch%0d expire got %b want %b", e.tag, e.ch, expire[e.ch], e.ex);
        bad = 1;
      end
      if (busy[e.ch] !== e.bz) begin
        $display("FAIL %s ch%0d busy got %b want %b", e.tag, e.ch, busy[e.ch], e.bz);
        bad = 1;
      end
      if (at_limit[e.ch] !== e.al) begin
        $display("FAIL %s ch%0d at_limit got %b want %b", e.tag, e.ch, at_limit[e.ch], e.al);
        bad = 1;
      end
    end
    if (bad) failed++;
  endtask

  // monitor: one expected entry per checked edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    reset = 1'b1; tick = 1'b0; start = '0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_reload = '0; cfg_floor = '0; cfg_mode = 2'b00;

    // 1: reset dominates tick and start
    drive(1, 1, '1, 0, 0, 0, 0, 0);  expect_ch("reset0", ALL, 0, 0, 0, 0);
    drive(1, 1, '1, 0, 0, 0, 0, 0);  expect_ch("reset1", ALL, 0, 0, 0, 0);

    // 2: one-shot down 5 -> 0
    drive(0, 0, 4'b0000, 1, 0, 5, 0, 2'b01); expect_ch("os_cfg", 0, 0, 0, 0, 1);
    drive(0, 0, 4'b0001, 0, 0, 0, 0, 0);     expect_ch("os_start", 0, 5, 0, 1, 0);
    for (int k = 1; k <= 7; k++) begin
      c = (5 - k < 0) ? 0 : 5 - k;
      drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);
      expect_ch("os_tick", 0, c, (k == 5), (k < 5), (c == 0));
    end

    // 3: auto-reload 3..1
    drive(0, 0, 4'b0000, 1, 1, 3, 1, 2'b10); expect_ch("ar_cfg", 1, 0, 0, 0, 0);
    drive(0, 0, 4'b0010, 0, 0, 0, 0, 0);     expect_ch("ar_start", 1, 3, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("ar_t1", 1, 2, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("ar_t2", 1, 1, 1, 1, 1);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("ar_t3", 1, 3, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("ar_t4", 1, 2, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("ar_t5", 1, 1, 1, 1, 1);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("ar_t6", 1, 3, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("ar_t7", 1, 2, 0, 1, 0);

    // 4: up 2 -> 31, then saturate
    drive(0, 0, 4'b0000, 1, 2, 31, 2, 2'b11); expect_ch("up_cfg", 2, 0, 0, 0, 0);
    drive(0, 0, 4'b0100, 0, 0, 0, 0, 0);      expect_ch("up_start", 2, 2, 0, 1, 0);
    for (int k = 1; k <= 31; k++) begin
      c = (2 + k > 31) ? 31 : 2 + k;
      drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);
      expect_ch("up_tick", 2, c, (k == 29), (k < 29), (c == 31));
    end

    // 5: start sees the old reload during a same-cycle config write; reset mid-count
    drive(0, 0, 4'b0001, 1, 0, 9, 0, 2'b01); expect_ch("samecyc", 0, 5, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("sc_t1", 0, 4, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("sc_t2", 0, 3, 0, 1, 0);
    drive(1, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("midreset", ALL, 0, 0, 0, 0);
    drive(0, 1, 4'b1111, 0, 0, 0, 0, 0);     expect_ch("off_start", ALL, 0, 0, 0, 0);

    // 6: one-shot with reload below floor expires immediately
    drive(0, 0, 4'b0000, 1, 3, 4, 7, 2'b01); expect_ch("inv_cfg", 3, 0, 0, 0, 0);
    drive(0, 0, 4'b1000, 0, 0, 0, 0, 0);     expect_ch("inv_start", 3, 7, 1, 0, 1);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("inv_t1", 3, 7, 0, 0, 1);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("inv_t2", 3, 7, 0, 0, 1);

    // writing mode 00 while busy drops busy; the tick at that edge still counts
    drive(0, 0, 4'b0000, 1, 1, 3, 0, 2'b10); expect_ch("off_cfg", 1, 0, 0, 0, 1);
    drive(0, 0, 4'b0010, 0, 0, 0, 0, 0);     expect_ch("off_go", 1, 3, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("off_t1", 1, 2, 0, 1, 0);
    drive(0, 1, 4'b0000, 1, 1, 3, 0, 2'b00); expect_ch("off_wr", 1, 1, 0, 0, 0);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("off_hold", 1, 1, 0, 0, 0);

    // auto-reload with reload <= floor pulses on every tick
    drive(0, 0, 4'b0000, 1, 2, 2, 4, 2'b10); expect_ch("deg_cfg", 2, 0, 0, 0, 0);
    drive(0, 0, 4'b0100, 0, 0, 0, 0, 0);     expect_ch("deg_start", 2, 4, 1, 1, 1);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("deg_t1", 2, 4, 1, 1, 1);
    drive(0, 0, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("deg_idle", 2, 4, 0, 1, 1);
    drive(0, 1, 4'b0000, 0, 0, 0, 0, 0);     expect_ch("deg_t2", 2, 4, 1, 1, 1);

    drive(0, 0, 4'b0000, 0, 0, 0, 0, 0);
    for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d entries left, want 0", sb.size());
      failed++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
